// File: rtl/torpedo_scheduler_if.sv
// Torpedo scheduler bus: frame sync, fire keys, ship spawn data, kill pulses in; slot state out.
// Latency: n/a (wiring only); all outputs are registered inside the scheduler.
// Backpressure: none; fire requests are level inputs and blocked requests are dropped.
// Ports (seen from the scheduler / slave side):
//   in : frame_clk, fire_p1/p2, ship{1,2}_{x,y,dir}, kill_p1/p2
//   out: torp{1,2}_{x,y} (10 bits per slot, packed), torp{1,2}_active, update_done
interface torpedo_scheduler_if #(
  parameter int SLOTS = 4
);
  logic                  frame_clk;
  logic                  fire_p1;
  logic                  fire_p2;
  logic [9:0]            ship1_x;
  logic [9:0]            ship1_y;
  logic [9:0]            ship2_x;
  logic [9:0]            ship2_y;
  logic [1:0]            ship1_dir;
  logic [1:0]            ship2_dir;
  logic [SLOTS-1:0]      kill_p1;
  logic [SLOTS-1:0]      kill_p2;
  logic [10*SLOTS-1:0]   torp1_x;
  logic [10*SLOTS-1:0]   torp1_y;
  logic [10*SLOTS-1:0]   torp2_x;
  logic [10*SLOTS-1:0]   torp2_y;
  logic [SLOTS-1:0]      torp1_active;
  logic [SLOTS-1:0]      torp2_active;
  logic                  update_done;

  modport master (
    output frame_clk, fire_p1, fire_p2, ship1_x, ship1_y, ship2_x, ship2_y,
           ship1_dir, ship2_dir, kill_p1, kill_p2,
    input  torp1_x, torp1_y, torp2_x, torp2_y, torp1_active, torp2_active, update_done
  );

  modport slave (
    input  frame_clk, fire_p1, fire_p2, ship1_x, ship1_y, ship2_x, ship2_y,
           ship1_dir, ship2_dir, kill_p1, kill_p2,
    output torp1_x, torp1_y, torp2_x, torp2_y, torp1_active, torp2_active, update_done
  );
endinterface

// File: rtl/torpedo_scheduler.sv
// Frame-synchronous torpedo slot manager for two players: spawn, cooldown, move, retire.
// Latency: a frame tick at cycle T runs MOVE T+1..T+2*SLOTS, SPAWN1, SPAWN2, DONE (T+11 by default).
// Backpressure: none; ticks outside IDLE are ignored, blocked fire requests are dropped.
// Ports: Clk, Reset (synchronous, active-high), bus (torpedo_scheduler_if.slave) carrying
//   frame_clk, fire keys, ship spawn position/heading, kill pulses in; packed slot
//   positions, active flags and the update_done pulse out.
module torpedo_scheduler #(
  parameter int SLOTS           = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int TORP_SPEED      = 4,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480
) (
  input  logic                Clk,
  input  logic                Reset,
  torpedo_scheduler_if.slave  bus
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int KW = $clog2(2 * SLOTS);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [KW-1:0] K_LAST  = KW'(2 * SLOTS - 1);
  localparam logic [KW-1:0] K_SLOTS = KW'(SLOTS);
  localparam logic [10:0]   SPEED   = 11'(TORP_SPEED);

  typedef enum logic [2:0] {IDLE, MOVE, SPAWN1, SPAWN2, DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;

  // Slot storage, first index is the player (0 = player 1, 1 = player 2).
  logic [9:0]       pos_x [2][SLOTS];
  logic [9:0]       pos_y [2][SLOTS];
  logic [1:0]       dir_r [2][SLOTS];
  logic [SLOTS-1:0] act   [2];
  logic [CW-1:0]    cd    [2];
  logic [1:0]       pend;
  logic [1:0]       fire_q;
  logic             frame_q;
  logic             done_q;

  // Per-player views of the inputs so both players share one code path.
  logic [1:0]       fire_in;
  logic [9:0]       ship_x   [2];
  logic [9:0]       ship_y   [2];
  logic [1:0]       ship_dir [2];
  logic [SLOTS-1:0] kill     [2];

  assign fire_in     = {bus.fire_p2, bus.fire_p1};
  assign ship_x[0]   = bus.ship1_x;
  assign ship_x[1]   = bus.ship2_x;
  assign ship_y[0]   = bus.ship1_y;
  assign ship_y[1]   = bus.ship2_y;
  assign ship_dir[0] = bus.ship1_dir;
  assign ship_dir[1] = bus.ship2_dir;
  assign kill[0]     = bus.kill_p1;
  assign kill[1]     = bus.kill_p2;

  logic       tick;
  logic [1:0] fire_edge;
  assign tick      = bus.frame_clk & ~frame_q;
  assign fire_edge = fire_in & ~fire_q;

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = MOVE;
          k_nxt     = '0;
        end
      end
      MOVE: begin
        if (k == K_LAST) begin
          state_nxt = SPAWN1;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      SPAWN1:  state_nxt = SPAWN2;
      SPAWN2:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared position adder: one slot per MOVE cycle, selected by k.
  logic          mv_p;
  logic [SW-1:0] mv_s;
  logic [1:0]    mv_dir;
  logic          mv_dec;
  logic [10:0]   mv_coord, mv_bound, mv_sum;
  logic          mv_off;

  always_comb begin
    mv_p     = (k >= K_SLOTS);
    mv_s     = SW'(mv_p ? (k - K_SLOTS) : k);
    mv_dir   = dir_r[mv_p][mv_s];
    // Headings 0 (up) and 2 (left) decrease the coordinate; bit 1 picks x over y.
    mv_dec   = ~mv_dir[0];
    mv_coord = mv_dir[1] ? {1'b0, pos_x[mv_p][mv_s]} : {1'b0, pos_y[mv_p][mv_s]};
    mv_bound = mv_dir[1] ? 11'(SCREEN_W) : 11'(SCREEN_H);
    mv_sum   = mv_coord + (mv_dec ? -SPEED : SPEED);
    mv_off   = mv_dec ? (mv_coord < SPEED) : (mv_sum >= mv_bound);
  end

  // Spawn selection: lowest-index free slot of the player being served.
  logic          sp_en, sp_p, sp_go;
  logic [SW-1:0] sp_s;

  always_comb begin
    sp_en = (state == SPAWN1) || (state == SPAWN2);
    sp_p  = (state == SPAWN2);
    sp_s  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!act[sp_p][i]) sp_s = SW'(i);
    end
    sp_go = sp_en && pend[sp_p] && (cd[sp_p] == '0) && !(&act[sp_p]);
  end

  // Datapath. Later assignments win, which is how kill overrides move/spawn.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < SLOTS; i++) begin
          pos_x[p][i] <= '0;
          pos_y[p][i] <= '0;
          dir_r[p][i] <= '0;
        end
        act[p] <= '0;
        cd[p]  <= '0;
      end
      pend    <= '0;
      fire_q  <= '0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      frame_q <= bus.frame_clk;
      fire_q  <= fire_in;
      done_q  <= (state_nxt == DONE);

      // A request is consumed by its SPAWN state whether or not it is served.
      if (sp_en) pend[sp_p] <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (fire_edge[p]) pend[p] <= 1'b1;
      end

      if (state == MOVE && k == '0) begin
        for (int p = 0; p < 2; p++) begin
          if (cd[p] != '0) cd[p] <= cd[p] - CW'(1);
        end
      end

      // A slot killed this cycle keeps its old position.
      if (state == MOVE && act[mv_p][mv_s] && !kill[mv_p][mv_s]) begin
        if (mv_off)         act[mv_p][mv_s]   <= 1'b0;
        else if (mv_dir[1]) pos_x[mv_p][mv_s] <= mv_sum[9:0];
        else                pos_y[mv_p][mv_s] <= mv_sum[9:0];
      end

      // The cooldown is charged even if a simultaneous kill eats the new torpedo.
      if (sp_go) begin
        cd[sp_p] <= CW'(COOLDOWN_FRAMES);
        if (!kill[sp_p][sp_s]) begin
          pos_x[sp_p][sp_s] <= ship_x[sp_p];
          pos_y[sp_p][sp_s] <= ship_y[sp_p];
          dir_r[sp_p][sp_s] <= ship_dir[sp_p];
          act[sp_p][sp_s]   <= 1'b1;
        end
      end

      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (kill[p][i]) act[p][i] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_out
    assign bus.torp1_x[10*i +: 10] = pos_x[0][i];
    assign bus.torp1_y[10*i +: 10] = pos_y[0][i];
    assign bus.torp2_x[10*i +: 10] = pos_x[1][i];
    assign bus.torp2_y[10*i +: 10] = pos_y[1][i];
  end

  assign bus.torp1_active = act[0];
  assign bus.torp2_active = act[1];
  assign bus.update_done  = done_q;

endmodule

// File: tb/tb_torpedo_scheduler.sv
// Directed bench for torpedo_scheduler: reset, spawn/move/cooldown, edge retire,
// pool full and reallocation, kill during move, and reset in the middle of a frame update.
module tb_torpedo_scheduler;
  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;
  int   timeouts;

  torpedo_scheduler_if #(.SLOTS(4)) bus ();

  torpedo_scheduler #(
    .SLOTS(4), .COOLDOWN_FRAMES(8), .TORP_SPEED(4), .SCREEN_W(640), .SCREEN_H(480)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [9:0] slot_of(input logic [39:0] v, input int i);
    return v[10*i +: 10];
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic pulse_fire(input logic f1, input logic f2);
    @(negedge Clk);
    bus.fire_p1 = f1;
    bus.fire_p2 = f2;
    @(negedge Clk);
    bus.fire_p1 = 1'b0;
    bus.fire_p2 = 1'b0;
  endtask

  task automatic pulse_kill(input logic [3:0] k1, input logic [3:0] k2);
    @(negedge Clk);
    bus.kill_p1 = k1;
    bus.kill_p2 = k2;
    @(negedge Clk);
    bus.kill_p1 = '0;
    bus.kill_p2 = '0;
  endtask

  // Raises frame_clk and counts rising edges from the tick edge until update_done is
  // seen (n = 1 after the tick edge). ev_n selects the cycle where kill_p1 / Reset are
  // driven for one clock. Returns at the negedge where update_done was observed high.
  task automatic run_frame(input int ev_n, input logic [3:0] ev_kill1, input logic ev_rst,
                           input logic expect_done, output int n, output logic got);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 30) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (n == 1) bus.frame_clk = 1'b0;
      bus.kill_p1 = '0;
      Reset       = 1'b0;
      if (bus.update_done === 1'b1) got = 1'b1;
      else if (n == ev_n) begin
        bus.kill_p1 = ev_kill1;
        Reset       = ev_rst;
      end
    end
    if (expect_done && !got) timeouts++;
  endtask

  task automatic frame();
    int   n;
    logic got;
    run_frame(-1, 4'b0000, 1'b0, 1'b1, n, got);
  endtask

  task automatic check_timeouts(input string name);
    // called at the end of each test; counts one comparison
    n_checks++;
    if (timeouts !== 0) begin
      n_fail++;
      $display("FAIL %s_frame_timeout: %0d frames missed update_done, required 0", name, timeouts);
    end
  endtask

  task automatic test_reset();
    int   n;
    logic got;
    timeouts = 0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (bus.torp1_active !== 4'b0000 || bus.torp2_active !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_active: got %b/%b required 0000/0000", bus.torp1_active, bus.torp2_active);
    end
    n_checks++;
    if (bus.update_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b required 0", bus.update_done);
    end
    n_checks++;
    if (bus.torp1_x !== '0 || bus.torp1_y !== '0 || bus.torp2_x !== '0 || bus.torp2_y !== '0) begin
      n_fail++;
      $display("FAIL reset_pos: got %h %h %h %h required all 0", bus.torp1_x, bus.torp1_y, bus.torp2_x, bus.torp2_y);
    end
    run_frame(-1, 4'b0000, 1'b0, 1'b1, n, got);
    n_checks++;
    if (got !== 1'b1 || n != 11) begin
      n_fail++;
      $display("FAIL idle_frame_latency: got done=%b after %0d cycles required done=1 after 11", got, n);
    end
    @(negedge Clk);
    n_checks++;
    if (bus.update_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %b one cycle later required 0", bus.update_done);
    end
    n_checks++;
    if (bus.torp1_active !== 4'b0000 || bus.torp2_active !== 4'b0000 || bus.torp1_x !== '0) begin
      n_fail++;
      $display("FAIL idle_frame_state: got act %b/%b x %h required 0", bus.torp1_active, bus.torp2_active, bus.torp1_x);
    end
  endtask

  task automatic test_spawn_move();
    timeouts = 0;
    do_reset();
    bus.ship1_x = 10'd100; bus.ship1_y = 10'd200; bus.ship1_dir = 2'd3;
    pulse_fire(1'b1, 1'b0);
    frame();  // frame 1: spawn
    n_checks++;
    if (bus.torp1_active !== 4'b0001 || slot_of(bus.torp1_x, 0) !== 10'd100 || slot_of(bus.torp1_y, 0) !== 10'd200) begin
      n_fail++;
      $display("FAIL spawn_p1: got act %b (%0d,%0d) required 0001 (100,200)", bus.torp1_active, slot_of(bus.torp1_x, 0), slot_of(bus.torp1_y, 0));
    end
    n_checks++;
    if (bus.torp2_active !== 4'b0000) begin
      n_fail++;
      $display("FAIL spawn_p2_untouched: got %b required 0000", bus.torp2_active);
    end
    frame();  // frame 2: move right
    n_checks++;
    if (slot_of(bus.torp1_x, 0) !== 10'd104 || slot_of(bus.torp1_y, 0) !== 10'd200) begin
      n_fail++;
      $display("FAIL move_right: got (%0d,%0d) required (104,200)", slot_of(bus.torp1_x, 0), slot_of(bus.torp1_y, 0));
    end
    pulse_fire(1'b1, 1'b0);
    frame();  // frame 3: cooldown 6 -> drop
    n_checks++;
    if (bus.torp1_active !== 4'b0001) begin
      n_fail++;
      $display("FAIL cooldown_drop_f3: got %b required 0001", bus.torp1_active);
    end
    for (int f = 4; f <= 7; f++) frame();
    pulse_fire(1'b1, 1'b0);
    frame();  // frame 8: cooldown 1 -> still blocked
    n_checks++;
    if (bus.torp1_active !== 4'b0001) begin
      n_fail++;
      $display("FAIL cooldown_drop_f8: got %b required 0001", bus.torp1_active);
    end
    bus.ship1_x = 10'd300; bus.ship1_y = 10'd50; bus.ship1_dir = 2'd0;
    pulse_fire(1'b1, 1'b0);
    frame();  // frame 9: cooldown reaches 0 -> slot1
    n_checks++;
    if (bus.torp1_active !== 4'b0011 || slot_of(bus.torp1_x, 1) !== 10'd300 || slot_of(bus.torp1_y, 1) !== 10'd50) begin
      n_fail++;
      $display("FAIL cooldown_expire_spawn: got act %b (%0d,%0d) required 0011 (300,50)", bus.torp1_active, slot_of(bus.torp1_x, 1), slot_of(bus.torp1_y, 1));
    end
    n_checks++;
    if (slot_of(bus.torp1_x, 0) !== 10'd132) begin
      n_fail++;
      $display("FAIL move_accumulate: got x %0d required 132", slot_of(bus.torp1_x, 0));
    end
    check_timeouts("spawn_move");
  endtask

  task automatic test_p2_retire();
    timeouts = 0;
    do_reset();
    bus.ship2_x = 10'd50; bus.ship2_y = 10'd6; bus.ship2_dir = 2'd0;
    pulse_fire(1'b0, 1'b1);
    frame();
    n_checks++;
    if (bus.torp2_active !== 4'b0001 || slot_of(bus.torp2_y, 0) !== 10'd6 || bus.torp1_active !== 4'b0000) begin
      n_fail++;
      $display("FAIL p2_spawn: got act2 %b y %0d act1 %b required 0001 6 0000", bus.torp2_active, slot_of(bus.torp2_y, 0), bus.torp1_active);
    end
    frame();
    n_checks++;
    if (bus.torp2_active !== 4'b0001 || slot_of(bus.torp2_y, 0) !== 10'd2) begin
      n_fail++;
      $display("FAIL p2_move_up: got act %b y %0d required 0001 2", bus.torp2_active, slot_of(bus.torp2_y, 0));
    end
    frame();
    n_checks++;
    if (bus.torp2_active !== 4'b0000 || slot_of(bus.torp2_y, 0) !== 10'd2 || slot_of(bus.torp2_x, 0) !== 10'd50) begin
      n_fail++;
      $display("FAIL p2_retire_top: got act %b (%0d,%0d) required 0000 (50,2)", bus.torp2_active, slot_of(bus.torp2_x, 0), slot_of(bus.torp2_y, 0));
    end
    check_timeouts("p2_retire");
  endtask

  task automatic test_full_pool();
    timeouts = 0;
    do_reset();
    bus.ship1_x = 10'd10; bus.ship1_y = 10'd0; bus.ship1_dir = 2'd1;
    for (int s = 0; s < 4; s++) begin
      pulse_fire(1'b1, 1'b0);
      frame();
      for (int f = 0; f < 7; f++) frame();
    end
    n_checks++;
    if (bus.torp1_active !== 4'b1111) begin
      n_fail++;
      $display("FAIL pool_fill: got %b required 1111", bus.torp1_active);
    end
    pulse_fire(1'b1, 1'b0);
    frame();
    n_checks++;
    if (bus.torp1_active !== 4'b1111) begin
      n_fail++;
      $display("FAIL pool_full_fire: got %b required 1111", bus.torp1_active);
    end
    pulse_kill(4'b0100, 4'b0000);
    n_checks++;
    if (bus.torp1_active !== 4'b1011) begin
      n_fail++;
      $display("FAIL kill_idle: got %b required 1011", bus.torp1_active);
    end
    frame();  // the dropped request must not come back
    n_checks++;
    if (bus.torp1_active !== 4'b1011) begin
      n_fail++;
      $display("FAIL pending_cleared: got %b required 1011", bus.torp1_active);
    end
    bus.ship1_x = 10'd77; bus.ship1_y = 10'd33;
    pulse_fire(1'b1, 1'b0);
    frame();
    n_checks++;
    if (bus.torp1_active !== 4'b1111 || slot_of(bus.torp1_x, 2) !== 10'd77 || slot_of(bus.torp1_y, 2) !== 10'd33) begin
      n_fail++;
      $display("FAIL realloc_slot2: got act %b (%0d,%0d) required 1111 (77,33)", bus.torp1_active, slot_of(bus.torp1_x, 2), slot_of(bus.torp1_y, 2));
    end
    check_timeouts("full_pool");
  endtask

  task automatic test_kill_during_move();
    int   n;
    logic got;
    timeouts = 0;
    do_reset();
    bus.ship1_x = 10'd100; bus.ship1_y = 10'd200; bus.ship1_dir = 2'd3;
    pulse_fire(1'b1, 1'b0);
    frame();
    run_frame(1, 4'b0001, 1'b0, 1'b1, n, got);  // kill while MOVE addresses slot0
    n_checks++;
    if (bus.torp1_active !== 4'b0000 || slot_of(bus.torp1_x, 0) !== 10'd100) begin
      n_fail++;
      $display("FAIL kill_in_move: got act %b x %0d required 0000 x 100", bus.torp1_active, slot_of(bus.torp1_x, 0));
    end
    check_timeouts("kill_move");
  endtask

  task automatic test_reset_mid_frame();
    int   n;
    logic got;
    bit   saw_done;
    timeouts = 0;
    do_reset();
    bus.ship1_x = 10'd100; bus.ship1_y = 10'd200; bus.ship1_dir = 2'd3;
    pulse_fire(1'b1, 1'b0);
    frame();
    run_frame(6, 4'b0000, 1'b1, 1'b0, n, got);  // Reset at MOVE index 5
    saw_done = got;
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got update_done at cycle %0d required none", n);
    end
    n_checks++;
    if (bus.torp1_active !== 4'b0000 || bus.torp1_x !== '0 || bus.torp1_y !== '0 || bus.update_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got act %b x %h y %h done %b required all 0", bus.torp1_active, bus.torp1_x, bus.torp1_y, bus.update_done);
    end
    pulse_fire(1'b1, 1'b0);
    run_frame(-1, 4'b0000, 1'b0, 1'b1, n, got);
    n_checks++;
    if (got !== 1'b1 || n != 11) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got done=%b after %0d cycles required done=1 after 11", got, n);
    end
    n_checks++;
    if (bus.torp1_active !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_cooldown: got %b required 0001", bus.torp1_active);
    end
    check_timeouts("reset_mid");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    timeouts = 0;
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.fire_p1 = 1'b0;    bus.fire_p2 = 1'b0;
    bus.ship1_x = '0;      bus.ship1_y = '0;    bus.ship1_dir = '0;
    bus.ship2_x = '0;      bus.ship2_y = '0;    bus.ship2_dir = '0;
    bus.kill_p1 = '0;      bus.kill_p2 = '0;
    test_reset();
    test_spawn_move();
    test_p2_retire();
    test_full_pool();
    test_kill_during_move();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/torpedo_scheduler.md
Name: torpedo_scheduler

Overview:
- Frame-synchronous controller for the torpedo sprite datapath: owns the torpedo slot pools for player 1 and player 2.
- Allocates slots on fire requests, enforces per-player cooldown, advances every active torpedo once per frame, and retires torpedoes that leave the screen or are hit.
- One time-multiplexed position adder is shared across all slots under FSM control.
- Outputs feed the torpedo sprite instances and color_mapper in place of software-supplied torpedo coordinates.

Parameters:
- SLOTS, 4, torpedo slots per player.
- COOLDOWN_FRAMES, 8, frames between successive spawns for one player.
- TORP_SPEED, 4, pixels moved per frame.
- SCREEN_W, 640, horizontal bound in pixels.
- SCREEN_H, 480, vertical bound in pixels.

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- frame_clk  input  1  VGA_VS; a rising edge marks a new frame.
- fire_p1, fire_p2  input  1 each  fire key level (held while pressed).
- ship1_x, ship1_y, ship2_x, ship2_y  input  10 each  ship spawn position.
- ship1_dir, ship2_dir  input  2 each  heading: 0 up, 1 down, 2 left, 3 right.
- kill_p1, kill_p2  input  SLOTS each  one-cycle pulse per slot from collision logic.
- torp1_x, torp1_y, torp2_x, torp2_y  output  10*SLOTS each  packed slot positions; slot i occupies bits [10i+9:10i].
- torp1_active, torp2_active  output  SLOTS each  slot valid flags.
- update_done  output  1  one-cycle pulse when the frame update completes.

Behaviour:
- Reset: the following are cleared to 0, and the FSM returns to IDLE within one cycle even mid-sequence:
  - all positions, active flags and stored directions;
  - cooldown counters and pending flags;
  - update_done and the frame_clk / fire edge registers.
- Frame tick: frame_clk and fire_px are registered each cycle.
  - tick is asserted in the cycle where frame_clk=1 and its previous sample was 0.
  - A fire rising edge sets pending_px.
- FSM states: IDLE, MOVE, SPAWN1, SPAWN2, DONE.
  - IDLE -> MOVE on tick. Ticks in any other state are ignored.
  - MOVE: index k steps 0..2*SLOTS-1, one slot per cycle. k<SLOTS addresses player 1 slot k; otherwise player 2 slot k-SLOTS. After the last index, go to SPAWN1.
  - SPAWN1 -> SPAWN2 -> DONE -> IDLE, one cycle each.
  - With defaults, tick at cycle T gives MOVE T+1..T+8, SPAWN1 T+9, SPAWN2 T+10, DONE T+11.
  - update_done is high during DONE only.
- Move rule for an active slot, using its stored direction d:
  - d=0 (up): if y < TORP_SPEED, deactivate; else y -= TORP_SPEED.
  - d=1 (down): if y+TORP_SPEED >= SCREEN_H, deactivate; else y += TORP_SPEED.
  - d=2 (left): if x < TORP_SPEED, deactivate; else x -= TORP_SPEED.
  - d=3 (right): if x+TORP_SPEED >= SCREEN_W, deactivate; else x += TORP_SPEED.
  - Comparisons use 11-bit arithmetic, so no wrap-around.
  - Inactive slots are untouched, and a deactivated slot keeps its last position.
- Cooldown: during the first MOVE cycle, each nonzero cooldown_px decrements by 1.
- Spawn rule, SPAWNx for player x:
  - Condition: pending_px=1, cooldown_px=0 and at least one inactive slot.
  - Action: take the lowest-index inactive slot, load x/y/dir from that player's ship inputs, set it active, and load cooldown_px=COOLDOWN_FRAMES.
  - pending_px is cleared in SPAWNx regardless of outcome; a blocked request is dropped, not queued.
  - A newly spawned torpedo is not moved until the next frame.
- Kill: kill_px[i] clears active[i] in the cycle it is seen, in any state.
  - Kill wins over a move or spawn write to the same slot in the same cycle; that spawn is lost, but the cooldown is still loaded.
- A fire edge arriving during MOVE sets pending and is served in the same frame's SPAWN.
- All outputs are registered; a write is visible the cycle after its state.

Test Plan:
- Reset, then one tick with no fire -> all active=0, update_done pulses exactly 11 cycles after the tick, positions 0.
- ship1=(100,200), dir=3, fire_p1 rising edge, tick -> slot0 active at (100,200). Next tick -> (104,200). Cooldown blocks a second fire within 8 frames (drop), and a fire at frame 9 lands in slot1.
- Player 2, dir=0 at y=6: spawn, then tick -> y=2; next tick -> slot deactivated, last position y=2 held.
- All 4 player-1 slots active (cooldown 0) and fire -> no change, pending cleared; kill_p1=4'b0100 then fire -> slot2 reallocated.
- kill_p1[0] asserted during the MOVE cycle for slot0 -> slot0 inactive, position not updated.
- Reset asserted at MOVE index 5 -> next cycle IDLE, everything cleared, no update_done; a subsequent tick runs the full sequence normally.
